// File: rtl/seq_chunk_adder_if.sv
// Operand/result bundle for the chunked adder: start/busy/done handshake
// plus operand inputs and registered result outputs.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, c,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, c,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: one CHUNK-bit ripple slice reused NCH times,
// with the carry held in a register between chunks.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic              clk,
  input logic              rst_n,
  seq_chunk_adder_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [CHUNK:0]   slice_s;
  logic [WIDTH-1:0] res_s;
  logic             msb_cin_s;

  // Next-state and datapath: operands shift right so the active chunk is always the low one
  always_comb begin
    slice_s   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    res_s     = (s_q >> CHUNK) | (WIDTH'(slice_s[CHUNK-1:0]) << (WIDTH - CHUNK));
    // On the final chunk the low slice holds the operand MSBs, so this recovers the carry into bit WIDTH-1.
    msb_cin_s = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ slice_s[CHUNK-1];

    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = done_q;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.c ^ bus.sub;
          idx_d   = '0;
          s_d     = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = slice_s[CHUNK];
        s_d     = res_s;
        if (idx_q == IW'(NCH - 1)) begin
          sum_d   = res_s;
          cout_d  = slice_s[CHUNK];
          ovf_d   = msb_cin_s ^ slice_s[CHUNK];
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: CHUNK=4 and CHUNK=16 instances checked against
// an integer-arithmetic reference model.
module tb_seq_chunk_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start_r;
  logic        sub_r;
  logic        c_r;
  logic [15:0] a_r;
  logic [15:0] b_r;

  int total = 0;
  int bad   = 0;
  logic [15:0] prev_sum [2];

  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(16)) if4 ();
  seq_chunk_adder_if #(.WIDTH(16)) if16 ();

  assign if4.start  = start_r[0];
  assign if16.start = start_r[1];
  assign if4.sub    = sub_r;
  assign if16.sub   = sub_r;
  assign if4.a      = a_r;
  assign if16.a     = a_r;
  assign if4.b      = b_r;
  assign if16.b     = b_r;
  assign if4.c      = c_r;
  assign if16.c     = c_r;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  wire [1:0]  busy_w = {if16.busy, if4.busy};
  wire [1:0]  done_w = {if16.done, if4.done};
  wire [1:0]  cout_w = {if16.cout, if4.cout};
  wire [1:0]  ovf_w  = {if16.ovf,  if4.ovf};
  logic [15:0] sum_w [2];
  assign sum_w[0] = if4.sum;
  assign sum_w[1] = if16.sum;

  // Reference: exact integer result, then reduce to {cout, ovf, sum}
  function automatic logic [17:0] model(input logic s, input logic [15:0] x, input logic [15:0] y,
                                        input logic ci);
    int ux = int'(x);
    int uy = int'(y);
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    int ic = ci ? 1 : 0;
    int ru;
    int rs;
    logic co;
    logic ov;
    if (!s) begin
      ru = ux + uy + ic;
      rs = sx + sy + ic;
      co = (ru > 65535);
    end else begin
      ru = ux - uy - ic;
      rs = sx - sy - ic;
      co = (ru >= 0);
    end
    ov = (rs > 32767) || (rs < -32768);
    return {co, ov, ru[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    a_r   = 16'($urandom);
    b_r   = 16'($urandom);
    c_r   = 1'($urandom);
    sub_r = 1'($urandom);
  endtask

  task automatic run_op(input int w, input logic s, input logic [15:0] oa, input logic [15:0] ob,
                        input logic oc, input logic [17:0] exp, input bit hammer, input string tag);
    int nch = (w == 0) ? 4 : 1;
    int n = 0;
    int done_at = -1;
    int done_cnt = 0;
    int busy_cnt = 0;
    logic [15:0] held = prev_sum[w];
    sub_r = s; a_r = oa; b_r = ob; c_r = oc;
    start_r[w] = 1'b1;
    @(posedge clk); #1;
    if (!hammer) start_r[w] = 1'b0;
    scramble();
    while (busy_w[w] && n < 40) begin
      busy_cnt++;
      if (done_w[w]) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = n;
          chk({tag, "_sum"},  32'(sum_w[w]),  32'(exp[15:0]));
          chk({tag, "_cout"}, 32'(cout_w[w]), 32'(exp[17]));
          chk({tag, "_ovf"},  32'(ovf_w[w]),  32'(exp[16]));
        end
      end else if (done_at < 0) begin
        chk({tag, "_hold"}, 32'(sum_w[w]), 32'(held));
      end
      @(posedge clk); #1;
      n++;
      if (hammer) scramble();
    end
    start_r[w] = 1'b0;
    chk({tag, "_timeout"}, 32'(n < 40), 32'd1);
    chk({tag, "_latency"}, 32'(done_at), 32'(nch));
    chk({tag, "_donecnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busycnt"}, 32'(busy_cnt), 32'(nch + 1));
    chk({tag, "_sumheld"}, 32'(sum_w[w]), 32'(exp[15:0]));
    prev_sum[w] = exp[15:0];
    @(posedge clk); #1;
    chk({tag, "_noqueue"}, 32'(busy_w[w]), 32'd0);
  endtask

  task automatic reset_mid(input int w);
    int k = (w == 0) ? 2 : 0;
    int dc = 0;
    sub_r = 1'b0; a_r = 16'h1357; b_r = 16'h2468; c_r = 1'b1;
    start_r[w] = 1'b1;
    @(posedge clk); #1;
    start_r[w] = 1'b0;
    repeat (k) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstmid_busy", 32'(busy_w[w]), 32'd0);
    chk("rstmid_done", 32'(done_w[w]), 32'd0);
    chk("rstmid_sum",  32'(sum_w[w]),  32'd0);
    chk("rstmid_cout", 32'(cout_w[w]), 32'd0);
    chk("rstmid_ovf",  32'(ovf_w[w]),  32'd0);
    prev_sum[0] = 16'h0000;
    prev_sum[1] = 16'h0000;
    repeat (10) begin
      @(posedge clk); #1;
      if (done_w[w]) dc++;
    end
    chk("rstmid_nodone", 32'(dc), 32'd0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rs;
    rst_n = 1'b0; start_r = 2'b00; sub_r = 1'b0; a_r = 16'h0000; b_r = 16'h0000; c_r = 1'b0;
    prev_sum[0] = 16'h0000;
    prev_sum[1] = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      chk("rst_busy", 32'(busy_w[w]), 32'd0);
      chk("rst_done", 32'(done_w[w]), 32'd0);
      chk("rst_sum",  32'(sum_w[w]),  32'd0);
      chk("rst_cout", 32'(cout_w[w]), 32'd0);
      chk("rst_ovf",  32'(ovf_w[w]),  32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int w = 0; w < 2; w++) begin
      run_op(w, 1'b0, 16'h1234, 16'h4321, 1'b0, {1'b0, 1'b0, 16'h5555}, 1'b0, "add");
      run_op(w, 1'b0, 16'hFFFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h0000}, 1'b0, "carry");
      run_op(w, 1'b0, 16'h7FFF, 16'h0000, 1'b1, {1'b0, 1'b1, 16'h8000}, 1'b0, "ovf");
      run_op(w, 1'b1, 16'h0005, 16'h0007, 1'b0, {1'b0, 1'b0, 16'hFFFE}, 1'b0, "sub_borrow");
      run_op(w, 1'b1, 16'h0009, 16'h0003, 1'b1, {1'b1, 1'b0, 16'h0005}, 1'b0, "sub_nobor");
      run_op(w, 1'b1, 16'h8000, 16'h0001, 1'b0, model(1'b1, 16'h8000, 16'h0001, 1'b0), 1'b1, "hammer");
      repeat (12) begin
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        run_op(w, rs, ra, rb, rc, model(rs, ra, rb, rc), 1'b0, "rand");
      end
      reset_mid(w);
      ra = 16'($urandom); rb = 16'($urandom);
      run_op(w, 1'b0, ra, rb, 1'b0, model(1'b0, ra, rb, 1'b0), 1'b0, "post_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor and the successor to the team's fixed 4-bit ripple adder.
- Processes a WIDTH-bit operand pair CHUNK bits per clock. A registered carry is passed between chunks, so one CHUNK-bit ripple slice is reused across cycles.
- Uses a start/busy/done handshake. Intended for datapaths where area matters more than single-cycle latency.
- Adds a subtract mode and signed overflow reporting, which the ripple adder lacks.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per clock. NCH = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0: sum = a + b + c. 1: sum = a - b - c.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- c  input  1  carry-in (add) or borrow-in (sub); sampled with start.
- busy  output  1  high while an operation is in progress (state != IDLE).
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1. In sub mode, 1 = no borrow.
- ovf  output  1  two's-complement overflow.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- rst_n=0 at a rising edge forces:
  - state = IDLE
  - busy = 0, done = 0, sum = 0, cout = 0, ovf = 0
  - internal chunk index, carry register and operand registers cleared
- Reset mid-operation aborts the operation. No done is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge T:
  - A_r <= a
  - B_r <= b when sub=0; B_r <= ~b when sub=1
  - carry_r <= c ^ sub
  - idx <= 0
  - state <= RUN
- IDLE, start=0: remain in IDLE.
- RUN, each edge:
  - {carry_r, S_r[idx*CHUNK +: CHUNK]} <= A_r chunk + B_r chunk + carry_r
  - idx <= idx+1
  - On the edge processing idx = NCH-1, state <= DONE instead.
- Edge T+NCH (entering DONE):
  - sum <= full result
  - cout <= final carry
  - ovf <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1
  - done <= 1
- DONE, next edge: state <= IDLE, done <= 0.
- Latency: done is high during the cycle after edge T+NCH, i.e. NCH+1 edges after start is sampled. Throughput is one operation per NCH+2 cycles.
- busy timing: busy = 1 from the cycle after edge T through the DONE cycle inclusive.
- start while busy (RUN or DONE, including the done cycle) is ignored. No queuing.
- a, b, c and sub may change freely after the start edge; they are not re-sampled.
- sum, cout and ovf change only on the edge entering DONE (or on reset). They hold until the next result.
- CHUNK = WIDTH is legal: NCH = 1, RUN lasts one cycle.
- idx is $clog2(NCH) bits wide, minimum 1. It never exceeds NCH-1.
- All arithmetic is modulo 2^WIDTH. Operands are treated as two's complement for ovf only.

Test Plan:
- WIDTH=16, CHUNK=4. Check add, no carry:
  - Stimulus: start=1, sub=0, a=0x1234, b=0x4321, c=0.
  - Response: done pulses once 5 edges later; sum=0x5555, cout=0, ovf=0; busy high for exactly 5 cycles.
- Carry propagation across all chunks:
  - Stimulus: a=0xFFFF, b=0x0001, c=0.
  - Response: sum=0x0000, cout=1, ovf=0.
- Signed overflow:
  - Stimulus: a=0x7FFF, b=0x0000, c=1.
  - Response: sum=0x8000, cout=0, ovf=1.
- Subtract with borrow:
  - Stimulus: sub=1, a=0x0005, b=0x0007, c=0.
  - Response: sum=0xFFFE, cout=0.
  - Stimulus: sub=1, a=0x0009, b=0x0003, c=1.
  - Response: sum=0x0005, cout=1.
- start while busy:
  - Stimulus: assert start=1 with new operands on every cycle of RUN and DONE.
  - Response: first result unaffected. A second operation begins only from the IDLE cycle after done.
- Reset mid-operation:
  - Stimulus: rst_n=0 for one edge at idx=2.
  - Response: busy=0, done=0, sum=0. No done pulse follows.
  - Repeat the tests with CHUNK=16; done must follow start by 2 edges.
